// File: rtl/lsu_mem_if_pkg.sv
// Shared types and helpers for the load/store unit front end.
// The LSU_MISALIGN_TRAP_EN build uses is_misaligned() to reject unaligned accesses.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } lsu_state_e;

  // The reserved encoding 2'b11 is folded onto a word access.
  function automatic lsu_size_e decode_size(input logic [1:0] raw);
    return (raw == 2'b11) ? WORD : lsu_size_e'(raw);
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
    return ((size == HALF) && lo[0]) || ((size == WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input lsu_size_e size);
    case (size)
      HALF:    return {addr[31:1], 1'b0};
      WORD:    return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and the memory (slave).
interface lsu_mem_if_if;

  logic        data_req;
  logic [31:0] data_adr;
  logic [31:0] data_write;
  logic        data_write_enable;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_read;

  modport master (
    output data_req, data_adr, data_write, data_write_enable,
    input  data_gnt, data_rvalid, data_read
  );

  modport slave (
    input  data_req, data_adr, data_write, data_write_enable,
    output data_gnt, data_rvalid, data_read
  );

endinterface

// File: rtl/lsu_mem_if_lane_fmt.sv
// Combinational lane logic: load extract/extend and sub-word store merge into a read word.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  byte_ofs;
  logic [4:0]  half_ofs;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_ofs  = {addr_lo, 3'b000};
  assign half_ofs  = {addr_lo[1], 4'b0000};
  assign byte_lane = rdata[byte_ofs +: 8];
  assign half_lane = rdata[half_ofs +: 16];

  always_comb begin
    load_data  = rdata;
    merge_data = rdata;
    unique case (size)
      BYTE: begin
        load_data                = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
        merge_data[byte_ofs +: 8] = wdata[7:0];
      end
      HALF: begin
        load_data                 = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
        merge_data[half_ofs +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// LSU front end: one outstanding access at a time, sub-word stores done as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning them.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1A00_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  lsu_mem_if_if.master bus
);

  lsu_state_e  state;
  lsu_size_e   size_q;
  logic        we_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        misalign_q;

  lsu_size_e   req_size;
  logic [31:0] addr_eff;
  logic        trap;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_size = decode_size(lsu_size_i);
  assign addr_eff = align_addr(lsu_addr_i, req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_size, lsu_addr_i[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign lsu_misalign_o = misalign_q;
  assign lsu_busy_o     = (state != IDLE);

  lsu_lane_fmt u_lane_fmt (
    .size        (size_q),
    .addr_lo     (addr_lo_q),
    .is_unsigned (unsigned_q),
    .rdata       (bus.data_read),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // Every bus output is a register updated alongside the state, so the bus is pure Moore.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                 <= IDLE;
      size_q                <= BYTE;
      we_q                  <= 1'b0;
      unsigned_q            <= 1'b0;
      addr_lo_q             <= 2'b00;
      wdata_q               <= 32'h0;
      misalign_q            <= 1'b0;
      lsu_rvalid_o          <= 1'b0;
      lsu_rdata_o           <= 32'h0;
      bus.data_req          <= 1'b0;
      bus.data_adr          <= 32'h0;
      bus.data_write        <= 32'h0;
      bus.data_write_enable <= 1'b0;
    end else begin
      lsu_rvalid_o <= 1'b0;
      misalign_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lsu_req_i && trap) begin
            misalign_q <= 1'b1;
          end else if (lsu_req_i) begin
            size_q       <= req_size;
            we_q         <= lsu_we_i;
            unsigned_q   <= lsu_unsigned_i;
            addr_lo_q    <= addr_eff[1:0];
            wdata_q      <= lsu_wdata_i;
            bus.data_adr <= {addr_eff[31:2], 2'b00};
            bus.data_req <= 1'b1;
            if (lsu_we_i && (req_size == WORD)) begin
              bus.data_write        <= lsu_wdata_i;
              bus.data_write_enable <= 1'b1;
              state                 <= WR_REQ;
            end else begin
              state <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (bus.data_gnt) begin
            bus.data_req <= 1'b0;
            state        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // A store reaching here is the read half of a read-modify-write.
          if (bus.data_rvalid && we_q) begin
            bus.data_write        <= merge_data;
            bus.data_write_enable <= 1'b1;
            bus.data_req          <= 1'b1;
            state                 <= WR_REQ;
          end else if (bus.data_rvalid) begin
            lsu_rdata_o  <= load_data;
            lsu_rvalid_o <= 1'b1;
            state        <= IDLE;
          end
        end
        WR_REQ: begin
          if (bus.data_gnt) begin
            bus.data_req          <= 1'b0;
            bus.data_write_enable <= 1'b0;
            state                 <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (bus.data_rvalid) begin
            lsu_rvalid_o <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  addr_above_base: assert property (@(posedge clk_i) disable iff (rst_i)
    ((state == IDLE) && lsu_req_i) |-> (lsu_addr_i >= BASE_ADDR));

endmodule
